bin_to_bcd: RTL and testbench
=============================

# bin_to_bcd

Sequential double-dabble converter that turns an unsigned binary value into packed BCD, one nibble per display digit. It sits directly upstream of the seven-segment digit scanner, and its `bcd_out` drives the scanner's 16-bit `din` nibble bus with the least significant digit in `[3:0]`. Values above the displayable range saturate to all nines and raise a flag.

## Interface

Parameters:
- `BIN_WIDTH`, default 14: width of the binary operand; legal range 1..32.
- `DIGIT_COUNT`, default 4: number of BCD digits produced; legal range 1..8.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `bin_in`  in  BIN_WIDTH: unsigned operand; sampled only on the accept edge.
- `in_valid`  in  1: operand present.
- `in_ready`  out  1: block is idle and can accept an operand.
- `bcd_out`  out  4*DIGIT_COUNT: packed BCD result; digit k sits in `[4k+3:4k]`.
- `out_valid`  out  1: one-cycle pulse; `bcd_out` and `overflow` are new this cycle.
- `overflow`  out  1: the last operand exceeded `MAX = 10^DIGIT_COUNT - 1`.

## Operation

- FSM states:
  - IDLE -> SHIFT on an accept (`in_valid && in_ready`).
  - SHIFT -> DONE after BIN_WIDTH steps.
  - DONE -> IDLE unconditionally.
- `in_ready` is 1 only in IDLE. It is decoded from the state register and has no combinational path from `in_valid`.
- On accept, the block loads an internal operand register with `min(bin_in, MAX)`.
  - It latches the pending overflow flag as `bin_in > MAX`.
  - It clears the BCD scratch register (4*DIGIT_COUNT bits).
  - It loads the step counter with BIN_WIDTH. The counter width is `$clog2(BIN_WIDTH+1)`.
- Each SHIFT edge performs one step:
  - Every scratch digit that is >= 5 gets +3.
  - {scratch, operand} then shifts left by 1, MSB of the operand first.
  - The step counter decrements.
- The edge on which the counter reaches 0 moves the FSM to DONE, copies scratch into `bcd_out`, copies the pending flag into `overflow`, and sets `out_valid`.
- Clamping guarantees the result fits in DIGIT_COUNT digits, so digits never exceed 9.
- `bcd_out` and `overflow` hold their values until the next DONE. They do not change during a subsequent conversion.
- While `in_ready` = 0, `in_valid` is ignored and `bin_in` may change freely.
- When `rst_n` is asserted at any point, including mid-SHIFT, the block goes to IDLE immediately and discards the in-flight conversion.
- Reset values:
  - `bcd_out` = 0, `overflow` = 0, `out_valid` = 0.
  - `in_ready` = 1 (state IDLE).
  - Counter and scratch = 0.
- Elaboration-time assertions reject out-of-range parameters.
- `MAX` is computed by a constant function and must fit in BIN_WIDTH bits or wider arithmetic. When `2^BIN_WIDTH - 1 <= MAX`, overflow can never assert.

## Timing

- Accept edge is E0.
- SHIFT steps occur on edges E1..E(BIN_WIDTH).
- `out_valid` = 1 during the cycle following E(BIN_WIDTH). Latency is BIN_WIDTH cycles from accept to result, which is 14 by default.
- At E(BIN_WIDTH+1) the FSM returns to IDLE and `out_valid` drops.
- `in_ready` rises in the cycle after E(BIN_WIDTH+1).
- The earliest next accept is edge E(BIN_WIDTH+2), giving a throughput of one conversion per BIN_WIDTH+2 cycles.
- If `in_valid` is held high continuously, conversions run back-to-back at that rate with no lost operands.

## Structure

- Add the following to the shared `seven_seg_pkg`:
  - `bcd_digit_t` (4-bit logic).
  - The constant `BCD_ADD3_THRESHOLD = 5`.
  - The constant function `bcd_max(digits)`.
- Sub-module `bcd_add3` (combinational): takes a `bcd_digit_t` and returns the value +3 if it is >= 5, otherwise unchanged. Instantiate it DIGIT_COUNT times in a generate loop.
- FSM state uses an enum typedef local to `bin_to_bcd`.

## Test plan

- **Reset:** after reset release, `bcd_out` = 0x0000, `overflow` = 0, `out_valid` = 0, `in_ready` = 1.
- **Basic conversion:** `bin_in` = 1234 accepted at E0 -> `out_valid` pulses exactly one cycle after E14, `bcd_out` = 0x1234, `overflow` = 0.
- **Range boundaries:** `bin_in` = 0 -> 0x0000; `bin_in` = 9999 -> 0x9999 with `overflow` = 0.
- **Saturation:** `bin_in` = 16383 -> `bcd_out` = 0x9999, `overflow` = 1. Following `bin_in` = 42 -> 0x0042 with `overflow` = 0.
- **Back-to-back:** `in_valid` held high with operands 7 then 8000 -> second accept 16 cycles after the first. Results 0x0007 then 0x8000. `bin_in` changes while busy are ignored.
- **Mid-conversion reset:** `rst_n` pulled low at E5 of a conversion of 5555 -> `out_valid` never pulses and `bcd_out` stays 0. After release, 321 converts to 0x0321.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment display path.
package seven_seg_pkg;

  // One packed BCD digit, as carried on the digit scanner's nibble bus.
  typedef logic [3:0] bcd_digit_t;

  // Double-dabble correction: digits at or above this value get +3 before a shift.
  localparam bcd_digit_t BCD_ADD3_THRESHOLD = 4'd5;

  // Largest value representable in 'digits' decimal digits: 10^digits - 1.
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit correction: adds 3 when the digit is >= 5.
module bcd_add3
  import seven_seg_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Correct the digit so the following left shift carries into the next decade.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADD3_THRESHOLD) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter with saturation to all nines.
//
// Handshake: an operand is accepted on a rising edge where in_valid && in_ready.
// in_ready is decoded purely from the state register (high only in IDLE), so
// in_valid never feeds back into it combinationally. out_valid is a one-cycle
// pulse marking new bcd_out/overflow; there is no output backpressure.
module bin_to_bcd
  import seven_seg_pkg::*;
#(
  parameter int BIN_WIDTH   = 14,
  parameter int DIGIT_COUNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BIN_WIDTH-1:0]     bin_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [4*DIGIT_COUNT-1:0] bcd_out,
  output logic                     out_valid,
  output logic                     overflow
);

  localparam int BCD_W = 4 * DIGIT_COUNT;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = bcd_max(DIGIT_COUNT);
  // Only used when bin_in exceeds MAX_VAL, which implies MAX_VAL fits in BIN_WIDTH bits.
  localparam logic [BIN_WIDTH-1:0] MAX_CLAMP = MAX_VAL[BIN_WIDTH-1:0];

  generate
    if (BIN_WIDTH < 1 || BIN_WIDTH > 32) begin : g_bad_bin_width
      $error("bin_to_bcd: BIN_WIDTH must be in 1..32");
    end
    if (DIGIT_COUNT < 1 || DIGIT_COUNT > 8) begin : g_bad_digit_count
      $error("bin_to_bcd: DIGIT_COUNT must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [BIN_WIDTH-1:0] operand;
  logic [BCD_W-1:0]     scratch;
  logic [CNT_W-1:0]     step_cnt;
  logic                 pend_ovf;

  logic                 accept;
  logic                 over_max;
  logic                 last_step;
  logic [BCD_W-1:0]     scratch_adj;
  logic [BCD_W-1:0]     scratch_next;
  logic [BIN_WIDTH-1:0] operand_next;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign over_max  = (64'(bin_in) > MAX_VAL);
  assign last_step = (step_cnt == CNT_W'(1));

  // One correction unit per scratch digit.
  generate
    for (genvar k = 0; k < DIGIT_COUNT; k++) begin : g_digit
      bcd_add3 u_add3 (
        .digit_in  (scratch[4*k +: 4]),
        .digit_out (scratch_adj[4*k +: 4])
      );
    end
  endgenerate

  // Shift the corrected scratch and operand left as one word, operand MSB first.
  always_comb begin
    logic [BCD_W+BIN_WIDTH-1:0] shifted;
    shifted      = {scratch_adj, operand} << 1;
    scratch_next = shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
    operand_next = shifted[BIN_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last_step) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, one double-dabble step per SHIFT cycle, publish on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand  <= '0;
      scratch  <= '0;
      step_cnt <= '0;
      pend_ovf <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == ST_IDLE && accept) begin
        operand  <= over_max ? MAX_CLAMP : bin_in;
        pend_ovf <= over_max;
        scratch  <= '0;
        step_cnt <= CNT_W'(BIN_WIDTH);
      end else if (state == ST_SHIFT) begin
        operand  <= operand_next;
        scratch  <= scratch_next;
        step_cnt <= step_cnt - CNT_W'(1);
        if (last_step) begin
          bcd_out  <= scratch_next;
          overflow <= pend_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd with default parameters (14-bit in, 4 digits).
module tb_bin_to_bcd;

  localparam int BW = 14;
  localparam int ND = 4;
  localparam int LAT = BW;       // accept edge to out_valid cycle
  localparam int PERIOD = BW + 2;

  logic            clk;
  logic            rst_n;
  logic [BW-1:0]   bin_in;
  logic            in_valid;
  logic            in_ready;
  logic [4*ND-1:0] bcd_out;
  logic            out_valid;
  logic            overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  logic prev_ov = 1'b0;

  logic [4*ND:0] exp_q[$];   // {overflow, bcd}
  int            acc_q[$];   // accept cycle for latency checks
  int            acc_log[$]; // all accept cycles, for spacing checks

  bin_to_bcd #(.BIN_WIDTH(BW), .DIGIT_COUNT(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: decimal arithmetic on the saturated value.
  function automatic logic [4*ND:0] ref_conv(input int v);
    int c;
    logic [4*ND-1:0] b;
    c = (v > 9999) ? 9999 : v;
    b = '0;
    for (int k = 0; k < ND; k++) begin
      b[4*k +: 4] = 4'(c % 10);
      c = c / 10;
    end
    return {(v > 9999), b};
  endfunction

  // Accept monitor: builds the expected queue from what the bench offered.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(ref_conv(int'(bin_in)));
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
  end

  // Result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_ov) check("out_valid_width", {31'd0, out_valid}, 32'd0);
      if (out_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          logic [4*ND:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(e[4*ND-1:0]));
          check("overflow", {31'd0, overflow}, {31'd0, e[4*ND]});
          check("latency", 32'(cyc - a), 32'(LAT));
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Offer one operand and return at the falling edge after it is accepted.
  task automatic send(input int v);
    int n;
    n = 0;
    bin_in   = BW'(v);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    bin_in   = BW'($urandom_range(0, (1 << BW) - 1));
  endtask

  // Wait until every expected result has appeared.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic convert(input int v);
    send(v);
    drain();
  endtask

  initial begin
    int p0;
    int base;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed values: basic, boundaries, saturation and recovery.
    convert(1234);
    convert(0);
    convert(9999);
    convert(16383);
    convert(42);
    convert(10000);
    convert(9998);
    convert(1);

    // Back-to-back with in_valid held high; operand changes while busy must be ignored.
    base = acc_log.size();
    bin_in   = BW'(7);
    in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 60 && acc_log.size() < base + 1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bin_in = BW'($urandom_range(0, (1 << BW) - 1));
      @(negedge clk);
    end
    bin_in = BW'(8000);
    for (int i = 0; i < 60 && acc_log.size() < base + 2; i++) @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepts", 32'(acc_log.size() - base), 32'd2);
    if (acc_log.size() >= base + 2)
      check("b2b_spacing", 32'(acc_log[base + 1] - acc_log[base]), 32'(PERIOD));
    drain();

    // Mid-conversion reset: assert at E5 of a 5555 conversion.
    p0 = pulses;
    send(5555);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    check("midrst_bcd_out", 32'(bcd_out), 32'h0);
    convert(321);

    // Randomized operands across the full input range.
    for (int i = 0; i < 30; i++) begin
      convert(int'($urandom_range(0, (1 << BW) - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    check("global_timeout", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
